// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: splits a 32-bit load/store into two 16-bit async SRAM accesses,
// each held for WAIT_CYCLES cycles. ready stalls the pipeline until the word completes.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  input  logic [15:0]       sram_rdata,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              op_wr;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       wdata_hi;

  logic              req;
  logic              cnt_last;
  logic [ADDR_W-1:0] base_in;
  logic              unused_addr_lsb;

  assign req      = mem_read | mem_write;
  assign cnt_last = (cnt == CNT_LAST);
  // Word address doubled gives the low half-word address; addr[1:0] is don't-care.
  assign base_in  = ADDR_W'({addr[31:2], 1'b0});
  assign unused_addr_lsb = ^addr[1:0];

  assign ready = ((state == IDLE) && !req) || (state == DONE);

  // SRAM strobes are registered: they are set up on the edge that enters LO/HI.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_wr      <= 1'b0;
      base_q     <= '0;
      wdata_hi   <= '0;
      rdata      <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state      <= LO;
            cnt        <= '0;
            op_wr      <= mem_write;
            base_q     <= base_in;
            wdata_hi   <= wdata[31:16];
            sram_addr  <= base_in;
            sram_wdata <= mem_write ? wdata[15:0] : 16'h0000;
            sram_we_n  <= ~mem_write;
            sram_oe_n  <= mem_write;
          end
        end
        LO: begin
          if (cnt_last) begin
            cnt        <= '0;
            state      <= HI;
            sram_addr  <= base_q | ADDR_W'(1);
            sram_wdata <= op_wr ? wdata_hi : 16'h0000;
            if (!op_wr) rdata[15:0] <= sram_rdata;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HI: begin
          if (cnt_last) begin
            cnt        <= '0;
            state      <= DONE;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            if (!op_wr) rdata[31:16] <= sram_rdata;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
